// File: rtl/dplca_table_pkg.sv
// Shared encodings and sizes for the D-PLCA TXOP claim table.
package dplca_table_pkg;
  localparam int TABLE_W = 256;
  localparam int DPLCA_AGE_CYCLES_DEF = 8;
  localparam logic [7:0] BEACON_ID = 8'd255;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    COLLECT,
    COMMIT
  } dplca_state_t;
endpackage

// File: rtl/dplca_max_claim_enc.sv
// Highest-set-bit priority encoder for the claim table.
// Combinational, zero latency; no flow control.
module dplca_max_claim_enc
  import dplca_table_pkg::*;
#(
  parameter int W = TABLE_W
) (
  input  logic [W-1:0] vec,
  output logic [7:0]   index,
  output logic         valid
);

  always_comb begin
    index = '0;
    valid = 1'b0;
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        index = 8'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dplca_txop_table_ctrl.sv
// Builds the per-PLCA-cycle TXOP claim table with age-period expiry of stale claims.
// Table, max_claim and upd appear two clocks after beacon_det; inputs are never stalled.
module dplca_txop_table_ctrl
  import dplca_table_pkg::*;
#(
  parameter int AGE_CYCLES = DPLCA_AGE_CYCLES_DEF,
  parameter int TABLE_W    = 256
) (
  input  logic               clk,
  input  logic               plca_reset,
  input  logic               dplca_aging,
  input  logic               beacon_det,
  input  logic               to_end,
  input  logic               to_busy,
  input  logic [7:0]         cur_id,
  output logic [TABLE_W-1:0] txop_claim_table,
  output logic               dplca_txop_table_upd,
  output logic               dplca_new_age,
  output logic [7:0]         max_claim,
  output logic               claim_valid
);

  localparam logic [7:0] AGE_LAST = 8'(AGE_CYCLES - 1);

  dplca_state_t       state;
  logic [TABLE_W-1:0] cyc_tab;
  logic [TABLE_W-1:0] age_acc;
  logic [7:0]         age_cnt;

  logic               claim;
  logic [TABLE_W-1:0] claim_vec;
  logic               age_last;
  logic [TABLE_W-1:0] tab_nxt;
  logic [7:0]         enc_idx;
  logic               enc_vld;

  assign claim     = to_end && to_busy && (cur_id != BEACON_ID);
  assign claim_vec = claim ? (TABLE_W'(1) << cur_id) : '0;
  assign age_last  = (age_cnt == AGE_LAST);

  // At the boundary the table is rebuilt from the closing period only,
  // which is what drops claims not seen for a full period.
  always_comb begin
    tab_nxt = txop_claim_table | cyc_tab;
    if (age_last) tab_nxt = age_acc | cyc_tab;
  end

  dplca_max_claim_enc #(.W(TABLE_W)) u_max_claim_enc (
    .vec   (tab_nxt),
    .index (enc_idx),
    .valid (enc_vld)
  );

  always_ff @(posedge clk or posedge plca_reset) begin
    if (plca_reset) begin
      state                <= IDLE;
      cyc_tab              <= '0;
      age_acc              <= '0;
      age_cnt              <= '0;
      txop_claim_table     <= '0;
      dplca_txop_table_upd <= 1'b0;
      dplca_new_age        <= 1'b0;
      max_claim            <= '0;
      claim_valid          <= 1'b0;
    end else if (!dplca_aging) begin
      state                <= IDLE;
      cyc_tab              <= '0;
      age_acc              <= '0;
      age_cnt              <= '0;
      txop_claim_table     <= '0;
      dplca_txop_table_upd <= 1'b0;
      dplca_new_age        <= 1'b0;
      max_claim            <= '0;
      claim_valid          <= 1'b0;
    end else begin
      dplca_txop_table_upd <= 1'b0;
      case (state)
        IDLE: state <= WAIT_SYNC;
        WAIT_SYNC: begin
          if (beacon_det) begin
            cyc_tab <= '0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          cyc_tab <= cyc_tab | claim_vec;
          if (beacon_det) state <= COMMIT;
        end
        COMMIT: begin
          txop_claim_table     <= tab_nxt;
          max_claim            <= enc_idx;
          claim_valid          <= enc_vld;
          dplca_txop_table_upd <= 1'b1;
          if (age_last) begin
            age_acc       <= '0;
            age_cnt       <= '0;
            dplca_new_age <= 1'b1;
          end else begin
            age_acc       <= age_acc | cyc_tab;
            age_cnt       <= age_cnt + 8'd1;
            dplca_new_age <= 1'b0;
          end
          // A TO ending during the commit clock lands in the fresh cycle table.
          cyc_tab <= claim_vec;
          state   <= COLLECT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dplca_txop_table_ctrl.sv
// Directed bench for the TXOP claim table controller, run with a 4-cycle age period.
module tb_dplca_txop_table_ctrl;

  logic         clk;
  logic         plca_reset;
  logic         dplca_aging;
  logic         beacon_det;
  logic         to_end;
  logic         to_busy;
  logic [7:0]   cur_id;
  logic [255:0] txop_claim_table;
  logic         dplca_txop_table_upd;
  logic         dplca_new_age;
  logic [7:0]   max_claim;
  logic         claim_valid;

  int checks   = 0;
  int failures = 0;

  dplca_txop_table_ctrl #(.AGE_CYCLES(4), .TABLE_W(256)) dut (
    .clk                  (clk),
    .plca_reset           (plca_reset),
    .dplca_aging          (dplca_aging),
    .beacon_det           (beacon_det),
    .to_end               (to_end),
    .to_busy              (to_busy),
    .cur_id               (cur_id),
    .txop_claim_table     (txop_claim_table),
    .dplca_txop_table_upd (dplca_txop_table_upd),
    .dplca_new_age        (dplca_new_age),
    .max_claim            (max_claim),
    .claim_valid          (claim_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] bv(input int id);
    logic [255:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beacon();
    beacon_det = 1'b1;
    tick();
    beacon_det = 1'b0;
  endtask

  task automatic txop(input int id, input logic busy);
    to_end  = 1'b1;
    to_busy = busy;
    cur_id  = 8'(id);
    tick();
    to_end  = 1'b0;
    to_busy = 1'b0;
    cur_id  = '0;
  endtask

  // Beacon then the COMMIT clock; returns with the refreshed outputs visible.
  task automatic do_commit();
    beacon();
    tick();
  endtask

  task automatic check_tab(input string tag, input logic [255:0] tab, input int mx,
                           input logic vld, input logic new_age);
    check({tag, "_table"}, txop_claim_table, tab);
    check({tag, "_max"}, 256'(max_claim), 256'(mx));
    check({tag, "_valid"}, 256'(claim_valid), 256'(vld));
    check({tag, "_upd"}, 256'(dplca_txop_table_upd), 256'd1);
    check({tag, "_new_age"}, 256'(dplca_new_age), 256'(new_age));
  endtask

  initial begin
    plca_reset  = 1'b1;
    dplca_aging = 1'b0;
    beacon_det  = 1'b0;
    to_end      = 1'b0;
    to_busy     = 1'b0;
    cur_id      = '0;
    tick();
    tick();
    plca_reset = 1'b0;
    tick();
    check("rst_table", txop_claim_table, '0);
    check("rst_max", 256'(max_claim), 256'd0);
    check("rst_valid", 256'(claim_valid), 256'd0);
    check("rst_upd", 256'(dplca_txop_table_upd), 256'd0);
    check("rst_new_age", 256'(dplca_new_age), 256'd0);

    // Basic cycle: busy TOs 0,3,7 plus an idle TO 5.
    dplca_aging = 1'b1;
    tick();
    beacon();
    txop(0, 1'b1);
    txop(3, 1'b1);
    txop(5, 1'b0);
    txop(7, 1'b1);
    beacon();
    check("basic_upd_in_commit", 256'(dplca_txop_table_upd), 256'd0);
    tick();
    check_tab("basic", 256'h89, 7, 1'b1, 1'b0);
    tick();
    check("basic_upd_pulse_end", 256'(dplca_txop_table_upd), 256'd0);

    // Async reset with three claims pending.
    txop(1, 1'b1);
    txop(2, 1'b1);
    txop(4, 1'b1);
    plca_reset = 1'b1;
    #2;
    check("arst_table", txop_claim_table, '0);
    check("arst_max", 256'(max_claim), 256'd0);
    check("arst_valid", 256'(claim_valid), 256'd0);
    tick();
    plca_reset = 1'b0;
    tick();
    beacon();
    tick();
    check("arst_no_upd_a", 256'(dplca_txop_table_upd), 256'd0);
    tick();
    check("arst_no_upd_b", 256'(dplca_txop_table_upd), 256'd0);
    check("arst_table_held", txop_claim_table, '0);
    txop(6, 1'b1);
    do_commit();
    check_tab("arst_first", bv(6), 6, 1'b1, 1'b0);

    // One-clock aging drop with a claim pending.
    txop(8, 1'b1);
    dplca_aging = 1'b0;
    tick();
    dplca_aging = 1'b1;
    check("drop_table", txop_claim_table, '0);
    check("drop_max", 256'(max_claim), 256'd0);
    check("drop_valid", 256'(claim_valid), 256'd0);
    tick();
    txop(12, 1'b1);
    beacon();
    txop(5, 1'b1);
    do_commit();
    check_tab("age_c1", bv(5), 5, 1'b1, 1'b0);
    do_commit();
    check_tab("age_c2", bv(5), 5, 1'b1, 1'b0);
    do_commit();
    check_tab("age_c3", bv(5), 5, 1'b1, 1'b0);
    do_commit();
    check_tab("age_b1", bv(5), 5, 1'b1, 1'b1);
    tick();
    tick();
    check("age_new_age_held", 256'(dplca_new_age), 256'd1);
    do_commit();
    check_tab("age_c5", bv(5), 5, 1'b1, 1'b0);
    do_commit();
    check_tab("age_c6", bv(5), 5, 1'b1, 1'b0);
    do_commit();
    check_tab("age_c7", bv(5), 5, 1'b1, 1'b0);
    txop(255, 1'b1);
    do_commit();
    check_tab("age_b2", '0, 0, 1'b0, 1'b1);
    do_commit();
    check_tab("empty", '0, 0, 1'b0, 1'b0);

    // Claim coincident with beacon, then a claim during COMMIT.
    beacon_det = 1'b1;
    to_end     = 1'b1;
    to_busy    = 1'b1;
    cur_id     = 8'd9;
    tick();
    beacon_det = 1'b0;
    txop(11, 1'b1);
    check_tab("coinc", bv(9), 9, 1'b1, 1'b0);
    do_commit();
    check_tab("in_commit", bv(9) | bv(11), 11, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
